icache_refill_line_fetch: RTL
=============================

Name: icache_refill_line_fetch

Overview:
- Upstream master for the granted word-memory port: converts one cache-line refill request into LINE_WORDS single-word reads.
- Honours GNT back-pressure on every word and collects Q on RVAL.
- Assembles the full line and returns it to the icache refill path over a valid/ready handshake.
- One line in flight at a time. Used as the L2-side refill engine in front of the memory model and the real memory macro.

Parameters:
ADDR_WIDTH, 12, word address width of the memory port
DATA_WIDTH, 64, memory word width in bits
LINE_WORDS, 4, words per cache line; power of two, >=2
BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived)

Ports:
CLK  input  1  clock
INITN  input  1  asynchronous active-low reset
refill_req_i  input  1  line refill request
refill_addr_i  input  ADDR_WIDTH  word address inside the requested line
refill_gnt_o  output  1  request accepted (combinational)
refill_rvalid_o  output  1  assembled line valid
refill_rdata_o  output  LINE_WORDS*DATA_WIDTH  line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
refill_rready_i  input  1  consumer accepts line
mem_cen_o  output  1  memory chip enable, active-low
mem_a_o  output  ADDR_WIDTH  memory word address
mem_gnt_i  input  1  memory grant
mem_wen_o  output  1  write enable, active-low; tied 1 (read-only)
mem_d_o  output  DATA_WIDTH  write data; tied 0
mem_be_o  output  BE_WIDTH  byte enables; tied all-ones
mem_q_i  input  DATA_WIDTH  read data
mem_rval_i  input  1  read data valid, one cycle after the granted request

Behaviour:
- Reset (INITN=0, async):
  - FSM=IDLE; issue and receive counters = 0; line buffer = 0.
  - refill_rvalid_o=0, mem_cen_o=1, mem_a_o=0, refill_gnt_o=0.
- Line base address: base = refill_addr_i with its low log2(LINE_WORDS) bits cleared, latched at accept. Word k address = base | k; never carries into the upper bits.
- IDLE:
  - refill_gnt_o = refill_req_i.
  - On req&gnt: latch base (and start offset, see option); go to ISSUE next cycle.
- ISSUE:
  - mem_cen_o=0, mem_a_o = current word address.
  - Issue counter advances only on mem_gnt_i=1. While mem_gnt_i=0, hold mem_a_o and keep mem_cen_o low.
  - On the grant of word LINE_WORDS-1 (the last issued word): go to WAIT; mem_cen_o=1 from the next cycle.
- WAIT: mem_cen_o=1. When the final word has been received, go to RESP.
- Receive (ISSUE and WAIT):
  - On mem_rval_i, mem_q_i is written to line slot (slot of the word granted in the previous cycle); receive counter increments.
  - The slot is tracked by a one-deep shadow of the last granted word index.
- RESP:
  - refill_rvalid_o=1; refill_rdata_o stable until refill_rready_i.
  - On rvalid&rready: go to IDLE, rvalid drops next cycle.
  - No new request is accepted in RESP.
- Latency, GNT always 1, LINE_WORDS=4:
  - accept at cycle 0; issues in cycles 1-4; RVAL in cycles 2-5.
  - refill_rvalid_o high from cycle 6.
  - Each GNT=0 cycle adds one cycle.
- mem_rval_i in IDLE or RESP is ignored. This covers a late response after a reset that lands mid-operation.
- refill_req_i deasserting after acceptance has no effect.
- refill_addr_i is sampled only at accept.
- Receive-counter width: log2(LINE_WORDS)+1 bits, so it can reach LINE_WORDS without wrapping.

Optional Feature:
ICACHE_REFILL_CWF_EN
- Defined: critical-word-first.
  - The first word issued is refill_addr_i[log2(LINE_WORDS)-1:0].
  - Subsequent words increment modulo LINE_WORDS, wrapping within the line.
  - Each word is stored in its true slot, so refill_rdata_o layout is unchanged.
- Undefined: issue order is always slot 0..LINE_WORDS-1. The low address bits are ignored.

Test Plan:
- Memory word i = {32'(8i+4),32'(8i)}; GNT=1; req addr 0x012 -> reads 0x010,0x011,0x012,0x013 in cycles 1-4; rvalid cycle 6; slot0 = 0x00000084_00000080, slot3 = 0x0000009C_00000098.
- GNT random 50% on addr 0x7FC -> mem_a_o held during each GNT=0 cycle; line = words 0x7FC-0x7FF, no address wrap to 0x000.
- rready held 0 for 5 cycles after rvalid, with a new request pending -> rdata stable, refill_gnt_o=0; new request accepted the cycle after the handshake.
- INITN pulsed low during ISSUE word 2 -> all outputs at reset values immediately; the next RVAL is ignored; a following request at 0x020 completes correctly.
- CWF_EN defined, addr 0x013 -> issue order 0x013,0x010,0x011,0x012; slot layout identical to the non-CWF fetch of the same line.
- Back-to-back requests, 20 random lines with GNT=1 -> each line matches the memory model; exactly LINE_WORDS CEN-low granted cycles per line.

Source files
------------

// File: rtl/icache_refill_line_fetch_if.sv
// Bundle for the refill engine: icache-side line handshake plus the word-memory request port.
// master = the refill engine, slave = icache consumer and memory seen together.
interface icache_refill_line_fetch_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 4
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                             refill_req_i;
  logic [ADDR_WIDTH-1:0]            refill_addr_i;
  logic                             refill_gnt_o;
  logic                             refill_rvalid_o;
  logic [LINE_WORDS*DATA_WIDTH-1:0] refill_rdata_o;
  logic                             refill_rready_i;
  logic                             mem_cen_o;
  logic [ADDR_WIDTH-1:0]            mem_a_o;
  logic                             mem_gnt_i;
  logic                             mem_wen_o;
  logic [DATA_WIDTH-1:0]            mem_d_o;
  logic [BE_WIDTH-1:0]              mem_be_o;
  logic [DATA_WIDTH-1:0]            mem_q_i;
  logic                             mem_rval_i;

  modport master (
    input  refill_req_i, refill_addr_i, refill_rready_i, mem_gnt_i, mem_q_i, mem_rval_i,
    output refill_gnt_o, refill_rvalid_o, refill_rdata_o,
           mem_cen_o, mem_a_o, mem_wen_o, mem_d_o, mem_be_o
  );

  modport slave (
    output refill_req_i, refill_addr_i, refill_rready_i, mem_gnt_i, mem_q_i, mem_rval_i,
    input  refill_gnt_o, refill_rvalid_o, refill_rdata_o,
           mem_cen_o, mem_a_o, mem_wen_o, mem_d_o, mem_be_o
  );
endinterface

// File: rtl/icache_refill_line_fetch.sv
// Refill engine: turns one line request into LINE_WORDS single-word memory reads and returns the line.
// Optional critical-word-first issue order when ICACHE_REFILL_CWF_EN is defined.
module icache_refill_line_fetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                 CLK,
  input  logic                 INITN,
  icache_refill_line_fetch_if.master bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFFW     = $clog2(LINE_WORDS);
  localparam int CNTW     = OFFW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  logic [ADDR_WIDTH-OFFW-1:0]       base_q, base_d;
  logic [OFFW-1:0]                  start_q, start_d;
  logic [CNTW-1:0]                  issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0]                  rx_cnt_q, rx_cnt_d;
  logic [OFFW-1:0]                  slot_q, slot_d;
  logic [LINE_WORDS*DATA_WIDTH-1:0] line_q, line_d;

  logic [OFFW-1:0] word_idx_s;
  logic            accept_s;
  logic            last_issue_s;
  logic            rx_hit_s;

  // Offset arithmetic is OFFW bits wide, so the word index wraps inside the line.
  assign word_idx_s   = start_q + issue_cnt_q[OFFW-1:0];
  assign accept_s     = (state_q == ST_IDLE) && bus.refill_req_i;
  assign last_issue_s = (issue_cnt_q == CNTW'(LINE_WORDS - 1));
  assign rx_hit_s     = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && bus.mem_rval_i;

  // Next-state, counters and line assembly.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    slot_d      = slot_q;
    line_d      = line_q;

    // slot_q is the word granted one cycle earlier, i.e. the one this RVAL answers.
    if (rx_hit_s) begin
      line_d[slot_q*DATA_WIDTH +: DATA_WIDTH] = bus.mem_q_i;
      rx_cnt_d = rx_cnt_q + CNTW'(1);
    end else begin
      rx_cnt_d = rx_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          base_d      = bus.refill_addr_i[ADDR_WIDTH-1:OFFW];
`ifdef ICACHE_REFILL_CWF_EN
          start_d     = bus.refill_addr_i[OFFW-1:0];
`else
          start_d     = '0;
`endif
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_gnt_i) begin
          slot_d      = word_idx_s;
          issue_cnt_d = issue_cnt_q + CNTW'(1);
          state_d     = last_issue_s ? ST_WAIT : ST_ISSUE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (rx_cnt_d == CNTW'(LINE_WORDS)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.refill_rready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge INITN) begin
    if (!INITN) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      slot_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      slot_q      <= slot_d;
      line_q      <= line_d;
    end
  end

  assign bus.refill_gnt_o    = accept_s;
  assign bus.refill_rvalid_o = (state_q == ST_RESP);
  assign bus.refill_rdata_o  = line_q;
  assign bus.mem_cen_o       = (state_q != ST_ISSUE);
  assign bus.mem_a_o         = {base_q, word_idx_s};
  assign bus.mem_wen_o       = 1'b1;
  assign bus.mem_d_o         = '0;
  assign bus.mem_be_o        = {BE_WIDTH{1'b1}};

endmodule
